// File: rtl/mips_pkg.sv
// Shared constants, enums and the ALU helper for the multicycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    // Arithmetic wraps modulo 2^32; slt is a signed compare.
    function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] res;
        case (op)
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = {31'b0, ($signed(a) < $signed(b))};
            default: res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 reads as zero.
module mips_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    // Register array; writes to $0 are dropped so entry 0 stays zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core with handshaked instruction and data ports.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  S_FETCH  | imem_req high at PC until imem_ready, latch IR
//  S_DECODE | latch rs/rt values and sign-extended immediate
//  S_EXEC   | ALU/branch/jump, PC update, illegal/misaligned detection
//  S_MEM    | dmem access held stable until dmem_ready
//  S_WB     | register write-back and retire
//  S_TRAP   | trap high, no requests, exit only via reset
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic [31:0] retire_pc,
    output logic        trap
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ipc_q, ipc_d, ir_q, ir_d;
    logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
    logic        run_q;

    logic [31:0] rf_rd1, rf_rd2, alu_res, pc_plus4, br_target, j_target;
    logic        rf_we, legal, misaligned, take_br;
    alu_op_e     alu_op;

    logic [5:0] opcode, funct;
    logic       is_r, is_j, is_beq, is_bne, is_lw, is_sw;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign is_r   = (opcode == OP_RTYPE);
    assign is_j   = (opcode == OP_J);
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);

    mips_regfile u_regfile (
        .clk_i  (clk),
        .rst_ni (reset),
        .ra1_i  (ir_q[25:21]),
        .ra2_i  (ir_q[20:16]),
        .rd1_o  (rf_rd1),
        .rd2_o  (rf_rd2),
        .we_i   (rf_we),
        .wa_i   (is_r ? ir_q[15:11] : ir_q[20:16]),
        .wd_i   (is_lw ? mdr_q : alu_q)
    );

    // Opcode/funct decode into ALU operation and legality.
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign alu_res    = alu_eval(alu_op, a_q, is_r ? b_q : imm_q);
    assign misaligned = (is_lw || is_sw) && (alu_res[1:0] != 2'b00);
    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = pc_plus4 + {imm_q[29:0], 2'b00};
    assign j_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign take_br    = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

    // Next-state, datapath latching and retire generation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        retire  = 1'b0;
        rf_we   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run_q && imem_ready) begin
                    ir_d    = imem_rdata;
                    ipc_d   = pc_q;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_rd1;
                b_d     = rf_rd2;
                imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!legal || misaligned) begin
                    if (TRAP_ON_ILLEGAL) begin
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    pc_d  = pc_plus4;
                    alu_d = alu_res;
                    if (is_j) begin
                        pc_d    = j_target;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (is_beq || is_bne) begin
                        if (take_br) pc_d = br_target;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers; run_q delays the first fetch by one edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ipc_q   <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            run_q   <= 1'b1;
        end
    end

    assign imem_req   = (state_q == S_FETCH) && run_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_req && is_sw;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign retire_pc  = ipc_q;
    assign trap       = (state_q == S_TRAP);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed-program bench with memory responders and a retire/store scoreboard.
module tb_mips_multicycle_core;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        retire, trap;
    logic [31:0] retire_pc;

    mips_multicycle_core #(.RESET_PC(RST_PC), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .retire_pc  (retire_pc),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] imem [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    logic [31:0] exp_ret [$];
    st_t         exp_st  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic st_t mk_st(input logic [31:0] a, input logic [31:0] d);
        st_t s;
        s.addr = a;
        s.data = d;
        return s;
    endfunction

    // Memory responders: ready after iwait/dwait stalled cycles of a held request.
    always @(negedge clk) begin
        if (imem_req) begin
            if (icnt >= iwait) begin
                imem_ready = 1'b1;
                imem_rdata = imem.exists(imem_addr) ? imem[imem_addr] : 32'hFC00_0000;
                icnt = 0;
            end else begin
                imem_ready = 1'b0;
                icnt++;
            end
        end else begin
            imem_ready = 1'b0;
            icnt = 0;
        end
        if (dmem_req) begin
            if (dcnt >= dwait) begin
                dmem_ready = 1'b1;
                dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : 32'h0;
                dcnt = 0;
            end else begin
                dmem_ready = 1'b0;
                dcnt++;
            end
        end else begin
            dmem_ready = 1'b0;
            dcnt = 0;
        end
    end

    always @(posedge clk) begin
        if (reset && dmem_req && dmem_we && dmem_ready) dmem[dmem_addr] = dmem_wdata;
    end

    // Monitor: pops expected retires/stores and checks request stability.
    logic        p_ireq = 0, p_iready = 0, p_dreq = 0, p_dready = 0, p_dwe = 0;
    logic [31:0] p_iaddr = 0, p_daddr = 0, p_dwdata = 0;
    always begin : monitor
        st_t s;
        @(negedge clk);
        #1;
        if (reset) begin
            check("req_exclusive", 32'(imem_req && dmem_req), 32'd0);
            if (retire) begin
                if (exp_ret.size() == 0) check("unexpected_retire_pc", retire_pc, 32'hFFFF_FFFF);
                else check("retire_pc", retire_pc, exp_ret.pop_front());
            end
            if (dmem_req && dmem_we && dmem_ready) begin
                if (exp_st.size() == 0) begin
                    check("unexpected_store_addr", dmem_addr, 32'hFFFF_FFFF);
                end else begin
                    s = exp_st.pop_front();
                    check("store_addr", dmem_addr, s.addr);
                    check("store_data", dmem_wdata, s.data);
                end
            end
            if (p_dreq && dmem_req && !p_dready) begin
                check("dmem_addr_stable", dmem_addr, p_daddr);
                check("dmem_wdata_stable", dmem_wdata, p_dwdata);
                check("dmem_we_stable", 32'(dmem_we), 32'(p_dwe));
            end
            if (p_ireq && imem_req && !p_iready) check("imem_addr_stable", imem_addr, p_iaddr);
        end
        p_ireq   = reset && imem_req;
        p_iready = imem_ready;
        p_iaddr  = imem_addr;
        p_dreq   = reset && dmem_req;
        p_dready = dmem_ready;
        p_daddr  = dmem_addr;
        p_dwdata = dmem_wdata;
        p_dwe    = dmem_we;
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_pc", imem_addr, RST_PC);
        check("leftover_retires", 32'(exp_ret.size()), 32'd0);
        check("leftover_stores", 32'(exp_st.size()), 32'd0);
        exp_ret.delete();
        exp_st.delete();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Counts cycles from the next cycle until n retires; expects exp_cyc cycles.
    task automatic run_until(input int n, input int exp_cyc, input string name, input bit chk_start);
        int r = 0;
        int cyc = 0;
        while (r < n && cyc < 400) begin
            @(negedge clk);
            #2;
            cyc++;
            if (chk_start && cyc == 1) begin
                check({name, "_first_req"}, 32'(imem_req), 32'd1);
                check({name, "_first_addr"}, imem_addr, RST_PC);
            end
            if (retire) r++;
        end
        if (r < n) check({name, "_timeout_retires"}, 32'(r), 32'(n));
        else check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic wait_trap(input string name);
        int cyc = 0;
        bit quiet = 1'b1;
        while (!trap && cyc < 50) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check({name, "_trap"}, 32'(trap), 32'd1);
        check({name, "_trap_cycles"}, 32'(cyc), 32'd4);
        repeat (10) begin
            @(negedge clk);
            #2;
            if (imem_req || dmem_req || retire || !trap) quiet = 1'b0;
        end
        check({name, "_trap_quiet"}, 32'(quiet), 32'd1);
    endtask

    initial begin : stim
        int cyc;
        // Program 1: ALU ops, stores/loads with wait states, $0 behaviour, wrap.
        imem.delete();
        dmem.delete();
        imem[32'h00] = 32'h2001_0005; // addi $1,$0,5
        imem[32'h04] = 32'h2002_FFFD; // addi $2,$0,-3
        imem[32'h08] = 32'h0022_1820; // add  $3,$1,$2
        imem[32'h0C] = 32'h0041_282A; // slt  $5,$2,$1
        imem[32'h10] = 32'hAC03_0008; // sw   $3,8($0)
        imem[32'h14] = 32'h8C04_0008; // lw   $4,8($0)
        imem[32'h18] = 32'hAC04_000C; // sw   $4,12($0)
        imem[32'h1C] = 32'hAC05_0010; // sw   $5,16($0)
        imem[32'h20] = 32'h0022_3022; // sub  $6,$1,$2
        imem[32'h24] = 32'h0022_3824; // and  $7,$1,$2
        imem[32'h28] = 32'h0022_4025; // or   $8,$1,$2
        imem[32'h2C] = 32'hAC06_0014; // sw   $6,20($0)
        imem[32'h30] = 32'hAC07_0018; // sw   $7,24($0)
        imem[32'h34] = 32'hAC08_001C; // sw   $8,28($0)
        imem[32'h38] = 32'h2000_0007; // addi $0,$0,7
        imem[32'h3C] = 32'hAC00_0020; // sw   $0,32($0)
        imem[32'h40] = 32'h2109_0004; // addi $9,$8,4
        imem[32'h44] = 32'hAC09_0024; // sw   $9,36($0)
        do_reset();
        exp_ret.push_back(32'h00);
        exp_ret.push_back(32'h04);
        exp_ret.push_back(32'h08);
        run_until(3, 12, "alu3", 1'b1);
        exp_ret.push_back(32'h0C);
        run_until(1, 4, "slt", 1'b0);
        dwait = 3;
        exp_ret.push_back(32'h10);
        exp_st.push_back(mk_st(32'd8, 32'd2));
        run_until(1, 7, "sw_wait3", 1'b0);
        exp_ret.push_back(32'h14);
        run_until(1, 8, "lw_wait3", 1'b0);
        exp_ret.push_back(32'h18);
        exp_st.push_back(mk_st(32'd12, 32'd2));
        run_until(1, 7, "sw_lw_data", 1'b0);
        dwait = 0;
        for (int a = 32'h1C; a <= 32'h44; a += 4) exp_ret.push_back(32'(a));
        exp_st.push_back(mk_st(32'd16, 32'd1));
        exp_st.push_back(mk_st(32'd20, 32'd8));
        exp_st.push_back(mk_st(32'd24, 32'd5));
        exp_st.push_back(mk_st(32'd28, 32'hFFFF_FFFD));
        exp_st.push_back(mk_st(32'd32, 32'd0));
        exp_st.push_back(mk_st(32'd36, 32'd1));
        run_until(11, 44, "mix", 1'b0);

        // Program 2: branches and jumps.
        imem.delete();
        imem[32'h000] = 32'h2001_0007; // addi $1,$0,7
        imem[32'h004] = 32'h1421_0005; // bne  $1,$1,5   (not taken)
        imem[32'h008] = 32'h1020_0005; // beq  $1,$0,5   (not taken)
        imem[32'h00C] = 32'h0800_0040; // j    0x40      -> 0x100
        imem[32'h100] = 32'h1021_FFC3; // beq  $1,$1,-61 -> 0x10
        imem[32'h010] = 32'h1421_FFFF; // bne  $1,$1,-1  (not taken)
        imem[32'h014] = 32'h0800_0004; // j    0x4       -> 0x10
        do_reset();
        exp_ret.push_back(32'h00);
        run_until(1, 4, "br_addi", 1'b1);
        exp_ret.push_back(32'h04);
        exp_ret.push_back(32'h08);
        exp_ret.push_back(32'h0C);
        run_until(3, 9, "br_nt_j", 1'b0);
        exp_ret.push_back(32'h100);
        run_until(1, 3, "beq_back", 1'b0);
        exp_ret.push_back(32'h10);
        run_until(1, 3, "bne_nt", 1'b0);
        imem[32'h010] = 32'h1021_FFFF; // beq $1,$1,-1 on the next visit
        @(negedge clk);
        #2;
        check("bne_next_addr", imem_addr, 32'h14);
        exp_ret.push_back(32'h14);
        exp_ret.push_back(32'h10);
        // fetch cycle of 0x14 was consumed by the check above
        run_until(2, 5, "j_beq", 1'b0);
        @(negedge clk);
        #2;
        check("beq_next_addr", imem_addr, 32'h10);
        check("beq_next_req", 32'(imem_req), 32'd1);

        // Program 3: reset clears registers, then unknown opcode traps.
        imem.delete();
        imem[32'h00] = 32'hAC03_0040; // sw $3,0x40($0)
        imem[32'h04] = 32'hFC00_0000; // opcode 6'h3F
        do_reset();
        exp_ret.push_back(32'h00);
        exp_st.push_back(mk_st(32'h40, 32'd0));
        run_until(1, 4, "rst_regs", 1'b1);
        wait_trap("op3f");

        // Program 4: misaligned load traps.
        imem.delete();
        imem[32'h00] = 32'h2001_0002; // addi $1,$0,2
        imem[32'h04] = 32'h8C22_0004; // lw   $2,4($1) -> addr 6
        do_reset();
        exp_ret.push_back(32'h00);
        run_until(1, 4, "mis_addi", 1'b1);
        wait_trap("lw_mis");

        // Program 5: reset while a load is stalled in MEM.
        imem.delete();
        dmem.delete();
        dmem[32'h0]  = 32'h1234_5678;
        imem[32'h00] = 32'h8C01_0000; // lw $1,0($0)
        imem[32'h04] = 32'hAC01_0004; // sw $1,4($0)
        dwait = 1000;
        do_reset();
        cyc = 0;
        while (!dmem_req && cyc < 20) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("midmem_req_seen", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("midmem_dmem_req_drop", 32'(dmem_req), 32'd0);
        check("midmem_imem_req", 32'(imem_req), 32'd0);
        check("midmem_retire", 32'(retire), 32'd0);
        check("midmem_pc", imem_addr, RST_PC);
        dwait = 0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_ret.push_back(32'h00);
        exp_ret.push_back(32'h04);
        exp_st.push_back(mk_st(32'h4, 32'h1234_5678));
        run_until(2, 9, "after_rst", 1'b1);

        repeat (2) @(negedge clk);
        #2;
        check("final_retires_left", 32'(exp_ret.size()), 32'd0);
        check("final_stores_left", 32'(exp_st.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter TRAP_ON_ILLEGAL, default 1, SHALL select the illegal/misaligned response: 1 = enter TRAP, 0 = execute as NOP.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-low.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address (equals PC).
REQ-007 imem_ready  input  1  fetch completes in any cycle with imem_req and imem_ready both high.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ready is high.
REQ-009 dmem_req  output  1  data access request.
REQ-010 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
REQ-011 dmem_addr  output  32  ALU-computed byte address.
REQ-012 dmem_wdata  output  32  store data (rt register value).
REQ-013 dmem_ready  input  1  data access completes when dmem_req and dmem_ready are both high.
REQ-014 dmem_rdata  input  32  load data, valid when dmem_ready is high.
REQ-015 retire  output  1  one-cycle pulse in the final cycle of each completed instruction.
REQ-016 retire_pc  output  32  PC of the retiring instruction, valid with retire.
REQ-017 trap  output  1  high while the core is in TRAP.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-019 FETCH SHALL hold imem_req high with a stable imem_addr until imem_ready, then latch IR and go to DECODE.
REQ-020 DECODE SHALL latch rs/rt register values and the sign-extended immediate, then go to EXEC.
REQ-021 Supported ops: add, sub, and, or, slt (R-type); lw, sw, addi, beq, bne, j.
REQ-022 slt SHALL compare signed; add, sub and addi SHALL wrap modulo 2^32 with no overflow exception.
REQ-023 EXEC SHALL set PC to PC+4 for all ops except taken branches and jumps.
REQ-024 Taken branch target SHALL be PC+4+(sext(imm)<<2); jump target SHALL be {PC+4[31:28], target26, 2'b00}.
REQ-025 Branch and jump instructions SHALL retire in EXEC and return to FETCH.
REQ-026 EXEC SHALL go to MEM for lw/sw and to WB for R-type and addi.
REQ-027 MEM SHALL hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ready.
REQ-028 On dmem_ready, sw SHALL retire and go to FETCH; lw SHALL latch dmem_rdata and go to WB.
REQ-029 WB SHALL write rd (R-type) or rt (lw/addi), retire, and go to FETCH.
REQ-030 Writes to $0 SHALL be discarded; reads of $0 SHALL return 0.
REQ-031 Minimum latencies with zero-wait memory: branch/jump 3 cycles, R-type/addi/sw 4, lw 5; each memory wait cycle SHALL add exactly one cycle.
REQ-032 An unknown opcode/funct, or a lw/sw address with [1:0]!=0, SHALL enter TRAP from EXEC when TRAP_ON_ILLEGAL=1.
REQ-033 In TRAP the core SHALL raise trap, drive no requests, not retire, and remain there until reset.
REQ-034 When TRAP_ON_ILLEGAL=0, an illegal instruction SHALL advance PC by 4 and retire with no other state change.
REQ-035 imem_req and dmem_req SHALL never be high in the same cycle.

Reset
REQ-036 Assertion SHALL immediately force: state=FETCH, PC=RESET_PC, IR=0, imem_req=0, dmem_req=0, dmem_we=0, retire=0, trap=0, all registers=0.
REQ-037 A memory request in flight at reset SHALL be abandoned; the first request after deassertion SHALL be a fetch from RESET_PC.
REQ-038 imem_req SHALL assert in the first rising edge after reset deassertion.

Structure
REQ-039 Package mips_pkg SHALL hold opcode/funct constants, the ALU-op enum and the FSM state enum.
REQ-040 The register file SHALL be the sub-module mips_regfile (32x32, 2 read ports, 1 write port, $0 hardwired to zero).

Verification
REQ-041 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> $3=2, three retire pulses, 12 cycles total with zero-wait memory.
REQ-042 sw $3,8($0) then lw $4,8($0) with dmem_ready delayed 3 cycles -> dmem_addr=8 held stable, $4=2, lw takes 8 cycles.
REQ-043 beq $1,$1,-1 at PC=0x10 -> next imem_addr=0x10; bne $1,$1 -> next imem_addr=0x14.
REQ-044 j 0x40 at PC=0x1000_0000 -> next imem_addr=0x1000_0100; slt $5,$2,$1 -> $5=1.
REQ-045 Opcode 6'h3F -> trap=1 with no further requests; lw at address 0x6 -> trap=1.
REQ-046 Reset asserted mid-MEM with dmem_ready low -> dmem_req drops immediately; after release the fetch is from RESET_PC.
